cal_capture_ctrl: RTL

//  Sequences capture of the 4-point sensor calibration table (N[0..3]) from the filtered ADC stream.
//  On a per-slot capture request: issues sample requests, averages 2^AVG_LOG2 filter outputs and checks monotonicity.

---
 rtl/cal_capture_ctrl_if.sv | 27 ++
 rtl/cal_capture_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cal_capture_ctrl_if.sv
// Signal bundle between the calibration capture controller and the filter,
// the front panel sequencer and the measurement interpolation datapath.
interface cal_capture_ctrl_if;
  logic        cal_start;
  logic [1:0]  cal_idx;
  logic        abort;
  logic        filter_valid;
  logic [15:0] filter_data;
  logic        sample_req;
  logic [1:0]  tbl_rd_idx;
  logic [15:0] tbl_rd_n;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_err;
  logic [1:0]  err_code;
  logic        beep_en;

  modport master (
    output cal_start, cal_idx, abort, filter_valid, filter_data, tbl_rd_idx,
    input  sample_req, tbl_rd_n, cal_busy, cal_done, cal_err, err_code, beep_en
  );

  modport slave (
    input  cal_start, cal_idx, abort, filter_valid, filter_data, tbl_rd_idx,
    output sample_req, tbl_rd_n, cal_busy, cal_done, cal_err, err_code, beep_en
  );
endinterface

// File: rtl/cal_capture_ctrl.sv
// Captures one slot of the 4-point calibration table by averaging filter
// outputs, enforces strict monotonicity, and serves the table to readers.
module cal_capture_ctrl #(
  parameter int          AVG_LOG2  = 3,
  parameter int          TIMEOUT   = 12000000,
  parameter int          BEEP_TIME = 1200000,
  parameter logic [15:0] N0        = 16'd918,
  parameter logic [15:0] N1        = 16'd27248,
  parameter logic [15:0] N2        = 16'd40001,
  parameter logic [15:0] N3        = 16'd51792
) (
  input logic               clk,
  input logic               rst_n,
  cal_capture_ctrl_if.slave bus
);
  localparam int DATA_W  = 16;
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int TMR_MAX = (TIMEOUT > BEEP_TIME) ? TIMEOUT : BEEP_TIME;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BEEP_LAST = TMR_W'(BEEP_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CHECK, S_COMMIT, S_BEEP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] tbl_q [4];
  logic [DATA_W-1:0] tbl_d [4];

  logic              sample_req_q, sample_req_d;
  logic              cal_busy_q, cal_busy_d;
  logic              cal_done_q, cal_done_d;
  logic              cal_err_q, cal_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              beep_en_q, beep_en_d;

  // Error exit raised by the next-state logic this cycle
  logic              err_vld;
  logic [1:0]        err_val;

  logic [DATA_W-1:0] avg;
  logic              lo_ok, hi_ok;

  assign avg   = acc_q[ACC_W-1:AVG_LOG2];
  // Index wrap at the table ends is harmless: the short-circuit masks it
  assign lo_ok = (idx_q == 2'd0) || (avg > tbl_q[idx_q - 2'd1]);
  assign hi_ok = (idx_q == 2'd3) || (avg < tbl_q[idx_q + 2'd1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      tbl_q[0]     <= N0;
      tbl_q[1]     <= N1;
      tbl_q[2]     <= N2;
      tbl_q[3]     <= N3;
      sample_req_q <= 1'b0;
      cal_busy_q   <= 1'b0;
      cal_done_q   <= 1'b0;
      cal_err_q    <= 1'b0;
      err_code_q   <= 2'b00;
      beep_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      tbl_q        <= tbl_d;
      sample_req_q <= sample_req_d;
      cal_busy_q   <= cal_busy_d;
      cal_done_q   <= cal_done_d;
      cal_err_q    <= cal_err_d;
      err_code_q   <= err_code_d;
      beep_en_q    <= beep_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    tbl_d   = tbl_q;
    err_vld = 1'b0;
    err_val = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (bus.cal_start) begin
          state_d = S_REQ;
          idx_d   = bus.cal_idx;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A sample arriving on the timeout cycle still counts
        if (bus.filter_valid) begin
          acc_d   = acc_q + ACC_W'(bus.filter_data);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_LAST) ? S_CHECK : S_REQ;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_vld = 1'b1;
          err_val = 2'b01;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (lo_ok && hi_ok) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_IDLE;
          err_vld = 1'b1;
          err_val = 2'b10;
        end
      end
      S_COMMIT: begin
        tbl_d[idx_q] = avg;
        timer_d      = '0;
        state_d      = S_BEEP;
      end
      S_BEEP: begin
        if (timer_q == BEEP_LAST) state_d = S_IDLE;
        else                      timer_d = timer_q + TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything; during BEEP it only silences the buzzer
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tbl_d   = tbl_q;
      err_vld = 1'b0;
      err_val = 2'b00;
      if (state_q != S_BEEP) begin
        err_vld = 1'b1;
        err_val = 2'b11;
      end
    end
  end

  always_comb begin
    sample_req_d = (state_d == S_REQ);
    cal_busy_d   = (state_d != S_IDLE);
    cal_done_d   = (state_d == S_COMMIT);
    beep_en_d    = (state_d == S_BEEP);
    cal_err_d    = err_vld;
    err_code_d   = err_code_q;
    if ((state_q == S_IDLE) && bus.cal_start) err_code_d = 2'b00;
    if (err_vld)                              err_code_d = err_val;
  end

  assign bus.sample_req = sample_req_q;
  assign bus.cal_busy   = cal_busy_q;
  assign bus.cal_done   = cal_done_q;
  assign bus.cal_err    = cal_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.beep_en    = beep_en_q;
  assign bus.tbl_rd_n   = tbl_q[bus.tbl_rd_idx];
endmodule
